byte_serial_adder64: RTL and testbench

- Multi-cycle 64-bit add engine that drives one eight_bit_adder instance byte by byte, least-significant byte first, and consumes its 8-bit sum and carry-out each cycle.
- Trades latency for area: one 8-bit slice is reused WIDTH/8 times instead of a full-width ripple chain.
- Sits between the operand source (register file or test harness) and the result consumer.
- Provides a start/busy/done handshake.

---
 rtl/byte_serial_adder64_pkg.sv | 17 +
 rtl/byte_serial_adder64_if.sv | 25 ++
 rtl/byte_serial_adder64_eight_bit_adder.sv | 15 +
 rtl/byte_serial_adder64.sv | 87 ++++++++
 tb/tb_byte_serial_adder64.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/byte_serial_adder64_pkg.sv
// Shared state encoding and slice sizing for the byte-serial adder.
// Pure declarations; no logic, no latency, no flow control.
package byte_serial_adder64_pkg;

    localparam int SLICE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nslice(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/byte_serial_adder64_if.sv
// Operand/result bundle for the byte-serial adder: start/busy/done handshake.
// Master drives operands and start; slave returns status and the result.
interface byte_serial_adder64_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/byte_serial_adder64_eight_bit_adder.sv
// 8-bit ripple slice with carry in/out; t1/t2 expose propagate/generate for debug.
// Combinational, zero latency, no flow control.
module eight_bit_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout,
    output logic [7:0] t1,
    output logic [7:0] t2
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    assign t1 = a ^ b;
    assign t2 = a & b;
endmodule

// File: rtl/byte_serial_adder64.sv
// Byte-serial WIDTH-bit adder reusing one 8-bit slice, LSB byte first.
// Latency NSLICE+1 cycles start-to-done; start is ignored while busy (no queueing).
module byte_serial_adder64
    import byte_serial_adder64_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    byte_serial_adder64_if.slave bus
);
    localparam int NSLICE = nslice(WIDTH);
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    state_t             state, state_nxt;
    logic [IDXW-1:0]    idx;
    logic               carry;
    logic [WIDTH-1:0]   a_reg, b_reg, sum_reg;
    logic               cout_reg, ovf_reg;
    logic [SLICE_W-1:0] sl_a, sl_b, sl_sum;
    logic               sl_cout;
    logic               accept, last;

    assign accept = bus.start && ((state == IDLE) || (state == DONE));
    assign last   = (state == ADD) && (idx == LAST_IDX);
    assign sl_a   = a_reg[idx*SLICE_W +: SLICE_W];
    assign sl_b   = b_reg[idx*SLICE_W +: SLICE_W];

    eight_bit_adder u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry),
        .sum  (sl_sum),
        .cout (sl_cout),
        .t1   (),
        .t2   ()
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = ADD;
            ADD:     if (idx == LAST_IDX) state_nxt = DONE;
            DONE:    state_nxt = bus.start ? ADD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            carry    <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_reg <= bus.a;
                b_reg <= bus.b;
                carry <= bus.cin;
                idx   <= '0;
            end else if (state == ADD) begin
                sum_reg[idx*SLICE_W +: SLICE_W] <= sl_sum;
                carry <= sl_cout;
                idx   <= last ? '0 : idx + IDXW'(1);
                // Signed overflow: like-signed operands producing a result of the other sign.
                if (last) begin
                    cout_reg <= sl_cout;
                    ovf_reg  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                (sl_sum[SLICE_W-1] != a_reg[WIDTH-1]);
                end
            end
        end
    end

    assign bus.busy     = (state == ADD);
    assign bus.done     = (state == DONE);
    assign bus.sum      = sum_reg;
    assign bus.cout     = cout_reg;
    assign bus.overflow = ovf_reg;

endmodule

// File: tb/tb_byte_serial_adder64.sv
// Directed bench for byte_serial_adder64 with a cycle-level arithmetic model.
module tb_byte_serial_adder64;
    localparam int WIDTH  = 64;
    localparam int NSLICE = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    byte_serial_adder64_if #(.WIDTH(WIDTH)) bus ();

    byte_serial_adder64 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: an accepted start computes the whole sum at once, then reveals it
    // one byte per cycle over NSLICE cycles, followed by a one-cycle done.
    logic [64:0] m_full;
    logic [63:0] m_sum, m_old, mask;
    logic        m_done, m_cout, m_ovf, m_amsb, m_bmsb;
    int          m_rem, k;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem = 0; m_done = 0; m_sum = '0; m_old = '0;
            m_cout = 0; m_ovf = 0; m_full = '0;
        end else if (m_rem > 0) begin
            m_rem = m_rem - 1;
            k = NSLICE - m_rem;
            mask = (k >= NSLICE) ? '1 : ((64'd1 << (8 * k)) - 64'd1);
            m_sum = (m_old & ~mask) | (m_full[63:0] & mask);
            if (m_rem == 0) begin
                m_done = 1;
                m_cout = m_full[64];
                m_ovf  = (m_amsb == m_bmsb) && (m_full[63] != m_amsb);
            end
        end else begin
            m_done = 0;
            if (bus.start) begin
                m_full = {1'b0, bus.a} + {1'b0, bus.b} + {64'd0, bus.cin};
                m_amsb = bus.a[63];
                m_bmsb = bus.b[63];
                m_old  = m_sum;
                m_rem  = NSLICE;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", {64'd0, bus.busy}, {64'd0, m_rem > 0});
        chk("done", {64'd0, bus.done}, {64'd0, m_done});
        chk("sum", {1'b0, bus.sum}, {1'b0, m_sum});
        chk("cout", {64'd0, bus.cout}, {64'd0, m_cout});
        chk("ovf", {64'd0, bus.overflow}, {64'd0, m_ovf});
    end

    task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic cin);
        bus.start = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.cin = cin;
    endtask

    // Called at the negedge where start is presented; returns on the done cycle.
    task automatic finish_op(input string nm, input logic [63:0] es, input logic ec,
                             input logic eo, input int inject);
        int c, nb;
        bit seen;
        c = 0; nb = 0; seen = 0;
        @(negedge clk);
        bus.start = 1'b0;
        while (c < 30) begin
            if (bus.busy) nb++;
            if (bus.done) begin
                seen = 1;
                break;
            end
            if (c == inject) begin
                bus.start = 1'b1;
                bus.a = '1;
                bus.b = '1;
                bus.cin = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            c++;
        end
        bus.start = 1'b0;
        chk({nm, "_seen"}, {64'd0, seen}, 65'd1);
        chk({nm, "_lat"}, 65'(c), 65'(NSLICE));
        chk({nm, "_busycyc"}, 65'(nb), 65'(NSLICE));
        chk({nm, "_sum"}, {1'b0, bus.sum}, {1'b0, es});
        chk({nm, "_cout"}, {64'd0, bus.cout}, {64'd0, ec});
        chk({nm, "_ovf"}, {64'd0, bus.overflow}, {64'd0, eo});
        chk({nm, "_msum"}, {1'b0, m_sum}, {1'b0, es});
    endtask

    task automatic no_done(input string nm, input int n);
        int d;
        d = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.done) d++;
        end
        chk(nm, 65'(d), 65'd0);
    endtask

    initial begin
        bus.start = 0; bus.a = '0; bus.b = '0; bus.cin = 0;
        #12;
        chk("rst_busy", {64'd0, bus.busy}, 65'd0);
        chk("rst_done", {64'd0, bus.done}, 65'd0);
        chk("rst_sum", {1'b0, bus.sum}, 65'd0);
        chk("rst_cout", {64'd0, bus.cout}, 65'd0);
        chk("rst_ovf", {64'd0, bus.overflow}, 65'd0);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);

        start_op(64'd1, 64'd1, 1'b0);
        finish_op("basic", 64'd2, 1'b0, 1'b0, -1);
        @(negedge clk);

        start_op('1, 64'd0, 1'b1);
        finish_op("ripple", 64'd0, 1'b1, 1'b0, -1);
        @(negedge clk);

        start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        finish_op("ovf_pos", 64'h8000_0000_0000_0000, 1'b0, 1'b1, -1);
        @(negedge clk);

        start_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        finish_op("ovf_neg", 64'd0, 1'b1, 1'b1, -1);
        @(negedge clk);

        start_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0);
        finish_op("busy_start", 64'h1234_5678_9ABC_DF00, 1'b0, 1'b0, 3);
        no_done("no_extra_done", 12);

        start_op(64'd10, 64'd20, 1'b1);
        finish_op("b2b_first", 64'd31, 1'b0, 1'b0, -1);
        start_op(64'd5, 64'd7, 1'b0);
        finish_op("b2b_second", 64'd12, 1'b0, 1'b0, -1);
        @(negedge clk);

        start_op(64'hDEAD_BEEF_0000_0001, 64'h1234_5678_9999_9999, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {64'd0, bus.busy}, 65'd0);
        chk("mid_rst_sum", {1'b0, bus.sum}, 65'd0);
        chk("mid_rst_cout", {64'd0, bus.cout}, 65'd0);
        chk("mid_rst_ovf", {64'd0, bus.overflow}, 65'd0);
        @(negedge clk);
        @(negedge clk);
        #3 rst_n = 1'b1;
        no_done("rst_no_done", 12);

        start_op(64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000, 1'b0);
        finish_op("post_rst", 64'd0, 1'b1, 1'b0, -1);
        @(negedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
